// File: rtl/pcie_tl_pkg.sv
// Shared types for the PCIe transaction-layer completion path: request payload,
// 3DW completion header layout and the helpers that build a TLP from a request.
package pcie_tl_pkg;

  localparam int unsigned DATA_WIDTH       = 256;
  localparam int unsigned TLP_HEADER_WIDTH = 128;
  localparam int unsigned DW_PER_BEAT      = DATA_WIDTH / 32;

  localparam logic [2:0] FMT_3DW_ND = 3'b000;
  localparam logic [2:0] FMT_3DW_D  = 3'b010;
  localparam logic [4:0] TYPE_CPL   = 5'b01010;

  typedef enum logic [2:0] {
    CPL_SC = 3'b000,
    CPL_UR = 3'b001,
    CPL_CA = 3'b100
  } cpl_status_e;

  typedef struct packed {
    cpl_status_e            status;
    logic [15:0]            requester_id;
    logic [9:0]             tag;
    logic [2:0]             tc;
    logic [2:0]             attr;
    logic [6:0]             lower_addr;
    logic [11:0]            byte_count;
    logic [3:0]             len_dw;
    logic [DATA_WIDTH-1:0]  data;
  } cpl_req_t;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [2:0]  tc;
    logic        ln;
    logic        th;
    logic        attr2;
    logic [1:0]  at;
    logic [1:0]  attr10;
    logic        td;
    logic        ep;
    logic [9:0]  length;
    logic [15:0] requester_id;
    logic [9:0]  tag;
    logic [2:0]  status;
    logic        bcm;
    logic [11:0] byte_count;
    logic [15:0] completer_id;
    logic [6:0]  lower_addr;
    logic [32:0] rsvd;
  } tlp_cpl_hdr_t;

  // Cpl carries no data and reports length 0; CplD reports the payload DW count.
  function automatic tlp_cpl_hdr_t fmt_cpl_hdr(cpl_req_t r, logic [15:0] cid);
    tlp_cpl_hdr_t h;
    logic         has_data;
    has_data       = (r.status == CPL_SC);
    h              = '0;
    h.fmt          = has_data ? FMT_3DW_D : FMT_3DW_ND;
    h.typ          = TYPE_CPL;
    h.tc           = r.tc;
    h.attr2        = r.attr[2];
    h.attr10       = r.attr[1:0];
    h.length       = has_data ? 10'(r.len_dw) : 10'd0;
    h.requester_id = r.requester_id;
    h.tag          = r.tag;
    h.status       = 3'(r.status);
    h.byte_count   = r.byte_count;
    h.completer_id = cid;
    h.lower_addr   = r.lower_addr;
    return h;
  endfunction

  // Zero every DW at or beyond the payload length; no payload at all for UR/CA.
  function automatic logic [DATA_WIDTH-1:0] cpl_payload(cpl_req_t r);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    if (r.status == CPL_SC) begin
      for (int unsigned i = 0; i < DW_PER_BEAT; i++) begin
        if (4'(i) < r.len_dw) d[i*32 +: 32] = r.data[i*32 +: 32];
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/pcie_tl_cpl_tx_if.sv
// Completion request stream (app -> TL) and single-beat TLP stream (TL -> DLL).
interface pcie_tl_cpl_tx_if;
  import pcie_tl_pkg::*;

  logic                        cpl_valid;
  logic                        cpl_ready;
  logic [2:0]                  cpl_status;
  logic [15:0]                 cpl_requester_id;
  logic [9:0]                  cpl_tag;
  logic [2:0]                  cpl_tc;
  logic [2:0]                  cpl_attr;
  logic [6:0]                  cpl_lower_addr;
  logic [11:0]                 cpl_byte_count;
  logic [3:0]                  cpl_len_dw;
  logic [DATA_WIDTH-1:0]       cpl_data;

  logic                        tx_valid;
  logic                        tx_ready;
  logic [TLP_HEADER_WIDTH-1:0] tx_header;
  logic [DATA_WIDTH-1:0]       tx_data;
  logic                        tx_sop;
  logic                        tx_eop;

  modport master (
    output cpl_valid, cpl_status, cpl_requester_id, cpl_tag, cpl_tc, cpl_attr,
           cpl_lower_addr, cpl_byte_count, cpl_len_dw, cpl_data, tx_ready,
    input  cpl_ready, tx_valid, tx_header, tx_data, tx_sop, tx_eop
  );

  modport slave (
    input  cpl_valid, cpl_status, cpl_requester_id, cpl_tag, cpl_tc, cpl_attr,
           cpl_lower_addr, cpl_byte_count, cpl_len_dw, cpl_data, tx_ready,
    output cpl_ready, tx_valid, tx_header, tx_data, tx_sop, tx_eop
  );
endinterface

// File: rtl/pcie_tl_sync_fifo.sv
// Synchronous FIFO with registered occupancy and registered empty/full flags.
module pcie_tl_sync_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         head_c,
  output logic                     not_empty,
  output logic                     not_full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [LW-1:0] level_nxt;

  assign do_push = push && not_full;
  assign do_pop  = pop && not_empty;
  assign head_c  = mem[rd_ptr];

  always_comb begin
    level_nxt = level + LW'(do_push) - LW'(do_pop);
  end

  // Flags come from next-state level so they are clean registers; not_full is low in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      not_empty <= 1'b0;
      not_full  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level     <= level_nxt;
      not_empty <= (level_nxt != '0);
      not_full  <= (level_nxt != LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pcie_tl_cpl_tx.sv
// Completion TX path: validates and queues completion requests, formats Cpl/CplD
// headers and holds one TLP beat toward the DLL under tx_ready backpressure.
module pcie_tl_cpl_tx
  import pcie_tl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   completer_id,
  pcie_tl_cpl_tx_if.slave               bus,
  output logic                          cpl_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          sent_cnt
);

  cpl_req_t req_c;
  cpl_req_t head_c;
  logic     req_ok_c;
  logic     push_c;
  logic     pop_c;
  logic     q_not_empty;
  logic     q_not_full;

  always_comb begin
    req_c.status       = cpl_status_e'(bus.cpl_status);
    req_c.requester_id = bus.cpl_requester_id;
    req_c.tag          = bus.cpl_tag;
    req_c.tc           = bus.cpl_tc;
    req_c.attr         = bus.cpl_attr;
    req_c.lower_addr   = bus.cpl_lower_addr;
    req_c.byte_count   = bus.cpl_byte_count;
    req_c.len_dw       = bus.cpl_len_dw;
    req_c.data         = bus.cpl_data;
  end

  // SC needs 1..8 payload DWs; UR/CA ignore length; any other status is malformed.
  always_comb begin
    req_ok_c = 1'b0;
    case (bus.cpl_status)
      CPL_SC:         req_ok_c = (bus.cpl_len_dw != 4'd0) && (bus.cpl_len_dw <= 4'(DW_PER_BEAT));
      CPL_UR, CPL_CA: req_ok_c = 1'b1;
      default:        req_ok_c = 1'b0;
    endcase
  end

  assign push_c        = bus.cpl_valid && q_not_full && req_ok_c;
  assign pop_c         = q_not_empty && (!bus.tx_valid || bus.tx_ready);
  assign bus.cpl_ready = q_not_full;

  pcie_tl_sync_fifo #(
    .T     (cpl_req_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .wdata     (req_c),
    .pop       (pop_c),
    .head_c    (head_c),
    .not_empty (q_not_empty),
    .not_full  (q_not_full),
    .level     (fifo_level)
  );

  // Output beat register: refills from the queue head whenever it is empty or being taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tx_valid  <= 1'b0;
      bus.tx_sop    <= 1'b0;
      bus.tx_eop    <= 1'b0;
      bus.tx_header <= '0;
      bus.tx_data   <= '0;
      cpl_err       <= 1'b0;
      sent_cnt      <= '0;
    end else begin
      cpl_err <= bus.cpl_valid && q_not_full && !req_ok_c;
      if (bus.tx_valid && bus.tx_ready) sent_cnt <= sent_cnt + CNT_WIDTH'(1);
      if (pop_c) begin
        bus.tx_valid  <= 1'b1;
        bus.tx_sop    <= 1'b1;
        bus.tx_eop    <= 1'b1;
        bus.tx_header <= fmt_cpl_hdr(head_c, completer_id);
        bus.tx_data   <= cpl_payload(head_c);
      end else if (bus.tx_ready) begin
        bus.tx_valid  <= 1'b0;
        bus.tx_sop    <= 1'b0;
        bus.tx_eop    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_tl_cpl_tx.sv
// Directed and randomized checks of the completion TX path against a header/payload model.
module tb_pcie_tl_cpl_tx;
  import pcie_tl_pkg::*;

  localparam logic [15:0] CID = 16'hA5C3;

  logic        clk;
  logic        rst_n;
  logic [15:0] completer_id;
  logic        cpl_err;
  logic [2:0]  fifo_level;
  logic [15:0] sent_cnt;

  int checks;
  int passes;

  pcie_tl_cpl_tx_if bus ();

  pcie_tl_cpl_tx u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .completer_id (completer_id),
    .bus          (bus),
    .cpl_err      (cpl_err),
    .fifo_level   (fifo_level),
    .sent_cnt     (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] exp_hdr(input cpl_req_t r);
    logic       sc;
    logic [2:0] f;
    logic [9:0] len;
    sc  = (r.status == CPL_SC);
    f   = sc ? 3'b010 : 3'b000;
    len = sc ? {6'd0, r.len_dw} : 10'd0;
    return {f, 5'b01010, r.tc, 1'b0, 1'b0, r.attr[2], 2'b00, r.attr[1:0], 1'b0, 1'b0,
            len, r.requester_id, r.tag, 3'(r.status), 1'b0, r.byte_count, CID,
            r.lower_addr, 33'd0};
  endfunction

  function automatic logic [255:0] exp_data(input cpl_req_t r);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      if ((r.status == CPL_SC) && (i < int'(r.len_dw))) d[i*32 +: 32] = r.data[i*32 +: 32];
    end
    return d;
  endfunction

  function automatic cpl_req_t mk(input logic [2:0] st, input logic [9:0] tag,
                                  input logic [3:0] len, input logic [255:0] data);
    cpl_req_t r;
    r.status       = cpl_status_e'(st);
    r.requester_id = 16'h0100;
    r.tag          = tag;
    r.tc           = 3'd2;
    r.attr         = 3'b101;
    r.lower_addr   = 7'h10;
    r.byte_count   = 12'h008;
    r.len_dw       = len;
    r.data         = data;
    return r;
  endfunction

  function automatic cpl_req_t rand_req();
    cpl_req_t r;
    int       s;
    s = int'($urandom_range(0, 5));
    r.status       = (s < 4) ? CPL_SC : ((s == 4) ? CPL_UR : CPL_CA);
    r.requester_id = 16'($urandom);
    r.tag          = 10'($urandom);
    r.tc           = 3'($urandom);
    r.attr         = 3'($urandom);
    r.lower_addr   = 7'($urandom);
    r.byte_count   = 12'($urandom);
    r.len_dw       = 4'($urandom_range(1, 8));
    for (int i = 0; i < 8; i++) r.data[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input cpl_req_t r);
    bus.cpl_status       = 3'(r.status);
    bus.cpl_requester_id = r.requester_id;
    bus.cpl_tag          = r.tag;
    bus.cpl_tc           = r.tc;
    bus.cpl_attr         = r.attr;
    bus.cpl_lower_addr   = r.lower_addr;
    bus.cpl_byte_count   = r.byte_count;
    bus.cpl_len_dw       = r.len_dw;
    bus.cpl_data         = r.data;
  endtask

  // Present a request and hold it until a handshake edge (bounded).
  task automatic send(input cpl_req_t r);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    drive(r);
    bus.cpl_valid = 1'b1;
    while (!acc && n < 64) begin
      acc = bus.cpl_ready;
      tick();
      n++;
    end
    chk("send_handshake", 256'(acc), 256'(1'b1));
  endtask

  cpl_req_t     r1;
  cpl_req_t     r2;
  cpl_req_t     rr;
  cpl_req_t     exp_q[$];
  logic [127:0] hprev;
  logic [255:0] dprev;
  logic         hs_in;
  logic         hold;
  int           n_sent;
  int           n_recv;
  int           cyc;

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    completer_id = CID;
    bus.cpl_valid = 1'b0;
    bus.tx_ready  = 1'b0;
    drive(mk(3'b000, 10'd0, 4'd1, '0));

    // Reset state
    tick();
    chk("rst_tx_valid", 256'(bus.tx_valid), 256'(1'b0));
    chk("rst_tx_sop", 256'(bus.tx_sop), 256'(1'b0));
    chk("rst_tx_header", 256'(bus.tx_header), 256'd0);
    chk("rst_tx_data", bus.tx_data, 256'd0);
    chk("rst_cpl_err", 256'(cpl_err), 256'(1'b0));
    chk("rst_fifo_level", 256'(fifo_level), 256'd0);
    chk("rst_sent_cnt", 256'(sent_cnt), 256'd0);
    chk("rst_cpl_ready", 256'(bus.cpl_ready), 256'(1'b0));
    rst_n = 1'b1;
    tick();
    chk("post_rst_cpl_ready", 256'(bus.cpl_ready), 256'(1'b1));

    // 1: SC completion, 2 DWs, upper DWs must be zeroed
    bus.tx_ready = 1'b1;
    r1 = mk(3'b000, 10'h2A5, 4'd2,
            256'h77777777_66666666_55555555_44444444_33333333_22222222_CAFEBABE_DEADBEEF);
    send(r1);
    bus.cpl_valid = 1'b0;
    chk("t1_latency_not_yet", 256'(bus.tx_valid), 256'(1'b0));
    tick();
    chk("t1_tx_valid", 256'(bus.tx_valid), 256'(1'b1));
    chk("t1_sop", 256'(bus.tx_sop), 256'(1'b1));
    chk("t1_eop", 256'(bus.tx_eop), 256'(1'b1));
    chk("t1_fmt", 256'(bus.tx_header[127:125]), 256'(3'b010));
    chk("t1_type", 256'(bus.tx_header[124:120]), 256'(5'b01010));
    chk("t1_tc", 256'(bus.tx_header[119:117]), 256'(3'd2));
    chk("t1_attr2", 256'(bus.tx_header[114]), 256'(1'b1));
    chk("t1_attr10", 256'(bus.tx_header[111:110]), 256'(2'b01));
    chk("t1_length", 256'(bus.tx_header[107:98]), 256'(10'd2));
    chk("t1_rid", 256'(bus.tx_header[97:82]), 256'(16'h0100));
    chk("t1_tag", 256'(bus.tx_header[81:72]), 256'(10'h2A5));
    chk("t1_status", 256'(bus.tx_header[71:69]), 256'(3'b000));
    chk("t1_bc", 256'(bus.tx_header[67:56]), 256'(12'h008));
    chk("t1_cid", 256'(bus.tx_header[55:40]), 256'(16'hA5C3));
    chk("t1_laddr", 256'(bus.tx_header[39:33]), 256'(7'h10));
    chk("t1_low_zero", 256'(bus.tx_header[32:0]), 256'd0);
    chk("t1_header_full", 256'(bus.tx_header), 256'(exp_hdr(r1)));
    chk("t1_data", bus.tx_data, 256'hCAFEBABE_DEADBEEF);
    tick();
    chk("t1_drained", 256'(bus.tx_valid), 256'(1'b0));
    chk("t1_sent_cnt", 256'(sent_cnt), 256'd1);

    // 2: UR completion carries no payload
    r2 = mk(3'b001, 10'h003, 4'd5, {8{32'h12345678}});
    send(r2);
    bus.cpl_valid = 1'b0;
    tick();
    chk("t2_tx_valid", 256'(bus.tx_valid), 256'(1'b1));
    chk("t2_fmt", 256'(bus.tx_header[127:125]), 256'(3'b000));
    chk("t2_length", 256'(bus.tx_header[107:98]), 256'd0);
    chk("t2_status", 256'(bus.tx_header[71:69]), 256'(3'b001));
    chk("t2_tag", 256'(bus.tx_header[81:72]), 256'(10'h003));
    chk("t2_data", bus.tx_data, 256'd0);
    chk("t2_sop", 256'(bus.tx_sop), 256'(1'b1));
    chk("t2_eop", 256'(bus.tx_eop), 256'(1'b1));
    tick();
    chk("t2_sent_cnt", 256'(sent_cnt), 256'd2);

    // 3: backpressure fills output register plus 4 queue entries
    bus.tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(mk(3'b000, 10'(10'h10 + k), 4'd1, {8{32'hA0A0A0A0}}));
    chk("t3_level_full", 256'(fifo_level), 256'd4);
    chk("t3_ready_low", 256'(bus.cpl_ready), 256'(1'b0));
    chk("t3_valid", 256'(bus.tx_valid), 256'(1'b1));
    drive(mk(3'b000, 10'h15, 4'd1, '0));
    bus.cpl_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_sixth_blocked", 256'(bus.cpl_ready), 256'(1'b0));
      chk("t3_level_hold", 256'(fifo_level), 256'd4);
      chk("t3_hdr_stable_tag", 256'(bus.tx_header[81:72]), 256'(10'h10));
      chk("t3_valid_hold", 256'(bus.tx_valid), 256'(1'b1));
    end
    bus.cpl_valid = 1'b0;
    bus.tx_ready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_order_valid", 256'(bus.tx_valid), 256'(1'b1));
      chk("t3_order_tag", 256'(bus.tx_header[81:72]), 256'(10'(10'h10 + k)));
      tick();
    end
    chk("t3_done_valid", 256'(bus.tx_valid), 256'(1'b0));
    chk("t3_sent_cnt", 256'(sent_cnt), 256'd7);
    chk("t3_level_empty", 256'(fifo_level), 256'd0);

    // 4: malformed requests are dropped with a one-cycle error pulse
    send(mk(3'b000, 10'h40, 4'd9, '1));
    chk("t4_err_len9", 256'(cpl_err), 256'(1'b1));
    chk("t4_level_len9", 256'(fifo_level), 256'd0);
    send(mk(3'b000, 10'h41, 4'd0, '1));
    chk("t4_err_len0", 256'(cpl_err), 256'(1'b1));
    chk("t4_level_len0", 256'(fifo_level), 256'd0);
    send(mk(3'b111, 10'h42, 4'd1, '1));
    chk("t4_err_badstat", 256'(cpl_err), 256'(1'b1));
    bus.cpl_valid = 1'b0;
    tick();
    chk("t4_err_clear", 256'(cpl_err), 256'(1'b0));
    chk("t4_no_tx", 256'(bus.tx_valid), 256'(1'b0));
    chk("t4_level_zero", 256'(fifo_level), 256'd0);

    // 5: random traffic and backpressure against an in-order scoreboard
    n_sent = 0;
    n_recv = 0;
    cyc    = 0;
    rr     = rand_req();
    while (n_recv < 1000 && cyc < 20000) begin
      if (n_sent < 1000 && $urandom_range(0, 99) < 60) begin
        rr = rand_req();
        drive(rr);
        bus.cpl_valid = 1'b1;
      end else begin
        bus.cpl_valid = 1'b0;
      end
      bus.tx_ready = ($urandom_range(0, 99) < 65);
      hs_in = bus.cpl_valid && bus.cpl_ready;
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("t5_spurious_beat", 256'(1'b1), 256'(1'b0));
        end else begin
          chk("t5_header", 256'(bus.tx_header), 256'(exp_hdr(exp_q[0])));
          chk("t5_data", bus.tx_data, exp_data(exp_q[0]));
          void'(exp_q.pop_front());
        end
        n_recv++;
      end
      hold  = bus.tx_valid && !bus.tx_ready;
      hprev = bus.tx_header;
      dprev = bus.tx_data;
      tick();
      cyc++;
      if (hs_in) begin
        exp_q.push_back(rr);
        n_sent++;
      end
      if (hold) begin
        chk("t5_hold_valid", 256'(bus.tx_valid), 256'(1'b1));
        chk("t5_hold_header", 256'(bus.tx_header), 256'(hprev));
        chk("t5_hold_data", bus.tx_data, dprev);
      end
    end
    bus.cpl_valid = 1'b0;
    chk("t5_recv_count", 256'(n_recv), 256'd1000);
    tick();
    chk("t5_sent_cnt", 256'(sent_cnt), 256'd1007);
    chk("t5_level_empty", 256'(fifo_level), 256'd0);

    // 6: asynchronous reset with queued and in-flight completions
    bus.tx_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(mk(3'b100, 10'(10'h20 + k), 4'd1, '0));
    bus.cpl_valid = 1'b0;
    tick();
    chk("t6_pre_valid", 256'(bus.tx_valid), 256'(1'b1));
    chk("t6_pre_level", 256'(fifo_level), 256'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 256'(bus.tx_valid), 256'(1'b0));
    chk("t6_rst_sop", 256'(bus.tx_sop), 256'(1'b0));
    chk("t6_rst_level", 256'(fifo_level), 256'd0);
    chk("t6_rst_sent_cnt", 256'(sent_cnt), 256'd0);
    chk("t6_rst_ready", 256'(bus.cpl_ready), 256'(1'b0));
    chk("t6_rst_header", 256'(bus.tx_header), 256'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
